fixed_to_float_rr_scheduler: RTL and testbench

Shares one external iterated fixed-to-float converter (start/ready/done handshake, single-precision result) between CHANNELS stream requesters. It arbitrates round-robin among valid inputs and issues one conversion at a time. It captures the result into a one-deep output register tagged with the source channel. A watchdog aborts conversions whose done never arrives.

---
 rtl/fixed_to_float_rr_scheduler.sv | 116 +++++++++++
 tb/tb_fixed_to_float_rr_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_rr_scheduler.sv
// Round-robin scheduler that shares one iterated fixed-to-float converter
// between CHANNELS sample streams. One conversion is in flight at a time.
// Each result lands in a one-deep output slot tagged with its source channel.
// A watchdog abandons a conversion whose done never arrives.
module fixed_to_float_rr_scheduler #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 16,
  parameter  int TIMEOUT  = 64,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      cvt_start,
  input  logic                      cvt_ready,
  input  logic                      cvt_done,
  output logic [WIDTH-1:0]          cvt_fixed,
  input  logic [31:0]               cvt_float,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      busy,
  output logic                      timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   chan_reg;
  logic [WDW-1:0]  wdog;
  logic [CW-1:0]   sel;
  logic [CW-1:0]   fix_sel;
  logic            grant;

  // Channel index p+k, wrapped modulo CHANNELS (CHANNELS need not be a power of two).
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] p, input int k);
    return CW'((int'(p) + k) % CHANNELS);
  endfunction

  // Round-robin pick: walk the offsets from farthest to nearest so the
  // nearest valid channel after rr_ptr is the one left in sel.
  always_comb begin
    sel = wrap_idx(rr_ptr, 1);
    for (int k = CHANNELS; k >= 1; k--) begin
      if (in_valid[wrap_idx(rr_ptr, k)]) sel = wrap_idx(rr_ptr, k);
    end
  end

  // Grant only from IDLE with a ready converter and a slot that is free or draining now.
  // Reset is folded in so nothing leaks combinationally while it is held.
  assign grant = !reset && (state == IDLE) && cvt_ready && (|in_valid) &&
                 (!out_valid || out_ready);

  assign cvt_start = grant;
  assign busy      = (state == BUSY);
  assign fix_sel   = grant ? sel : wrap_idx(rr_ptr, 1);

  // Input handshake and converter operand; without a grant the operand is a harmless known value.
  always_comb begin
    in_ready  = '0;
    cvt_fixed = reset ? '0 : in_data[fix_sel*WIDTH +: WIDTH];
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = grant && (sel == CW'(i));
    end
  end

  // Control FSM, watchdog and output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= CW'(CHANNELS - 1);
      chan_reg  <= '0;
      wdog      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // cvt_done seen here belongs to an abandoned conversion: ignored.
          if (grant) begin
            rr_ptr   <= sel;
            chan_reg <= sel;
            wdog     <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cvt_done) begin
            // Slot is guaranteed empty here: grant required it free or draining.
            out_data  <= cvt_float;
            out_chan  <= chan_reg;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float_rr_scheduler.sv
// Self-checking bench: table-driven conversions, hand sequences for
// back-pressure, fairness, watchdog and reset, then randomized traffic
// against a queue-based reference model. Includes a behavioural converter.
module tb_fixed_to_float_rr_scheduler;
  localparam int CH = 4, W = 16, TO = 64, CW = 2;

  logic              clk = 1'b0, reset = 1'b1;
  logic [CH-1:0]     in_valid = '0;
  logic [CH*W-1:0]   in_data = '0;
  logic [CH-1:0]     in_ready;
  logic              cvt_start, cvt_ready, cvt_done;
  logic [W-1:0]      cvt_fixed;
  logic [31:0]       cvt_float;
  logic              out_valid, out_ready = 1'b0;
  logic [31:0]       out_data;
  logic [CW-1:0]     out_chan;
  logic              busy, timeout;

  fixed_to_float_rr_scheduler #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TO)) dut (
    .reset(reset), .clk(clk), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cvt_start(cvt_start), .cvt_ready(cvt_ready),
    .cvt_done(cvt_done), .cvt_fixed(cvt_fixed), .cvt_float(cvt_float),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy), .timeout(timeout));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Exact int16 -> IEEE single (16-bit magnitudes never need rounding).
  function automatic logic [31:0] ref_float(input logic signed [W-1:0] x);
    int v, mag, e;
    v = int'(x);
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    return {(v < 0), 8'(127 + e), 23'((mag << (23 - e)) & 32'h7FFFFF)};
  endfunction

  // Behavioural converter. mode 0: data-dependent latency (0 for zero/-32768),
  // mode 1: accepts nothing and never finishes, mode 2: fixed latency.
  int          mode = 0, fixed_lat = 0, ccnt = 0;
  logic        cbusy = 1'b0;
  logic [31:0] cres = '0;
  assign cvt_ready = (mode == 1) ? 1'b1 : !cbusy;
  assign cvt_done  = cbusy && (ccnt == 0);
  assign cvt_float = cvt_done ? cres : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (cvt_start && !cbusy && mode != 1) begin
      cbusy <= 1'b1;
      cres  <= ref_float(cvt_fixed);
      if (mode == 2) ccnt <= fixed_lat;
      else if (cvt_fixed == 16'h0000 || cvt_fixed == 16'h8000) ccnt <= 0;
      else ccnt <= int'($urandom_range(1, W));
    end else if (cbusy) begin
      if (ccnt == 0) cbusy <= 1'b0;
      else ccnt <= ccnt - 1;
    end
  end

  task automatic wait_start(input string nm);
    for (int n = 0; n < 300 && !cvt_start; n++) begin @(negedge clk); #1; end
    chk(nm, 32'(cvt_start), 32'd1);
  endtask

  task automatic wait_out(input string nm);
    for (int n = 0; n < 300 && !out_valid; n++) begin @(negedge clk); #1; end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    for (int n = 0; n < 300 && (busy || out_valid || !cvt_ready); n++) begin
      @(negedge clk); #1;
    end
    chk(nm, 32'(busy || out_valid), 32'd0);
  endtask

  // One isolated conversion on channel ch, then drain.
  task automatic do_one(input int ch, input logic [W-1:0] d, input logic [31:0] f);
    @(negedge clk); in_data[ch*W +: W] = d; in_valid[ch] = 1'b1; out_ready = 1'b0; #1;
    wait_start("one_start");
    chk("one_in_ready", 32'(in_ready), 32'(1 << ch));
    chk("one_fixed", 32'(cvt_fixed), 32'(d));
    @(negedge clk); in_valid[ch] = 1'b0; #1;
    wait_out("one_out");
    chk("one_data", out_data, f);
    chk("one_chan", 32'(out_chan), 32'(ch));
    @(negedge clk); out_ready = 1'b1; #1;
    @(negedge clk); out_ready = 1'b0; #1;
    chk("one_drained", 32'(out_valid), 32'd0);
  endtask

  typedef struct { int ch; logic [W-1:0] d; logic [31:0] f; } vec_t;
  typedef struct { int ch; logic [31:0] f; } exp_t;

  vec_t tbl[8];
  vec_t rr[5];
  exp_t q[$];

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    int bc, ov, tc, n0, mptr, e;
    logic got2;
    logic [CH-1:0] acc;
    logic exp_g;
    exp_t x;

    tbl[0] = '{0, 16'h0001, 32'h3F800000};
    tbl[1] = '{1, 16'h0100, 32'h43800000};
    tbl[2] = '{2, 16'hFFFF, 32'hBF800000};
    tbl[3] = '{3, 16'h0000, 32'h00000000};
    tbl[4] = '{0, 16'h8000, 32'hC7000000};
    tbl[5] = '{1, 16'h7FFF, 32'h46FFFE00};
    tbl[6] = '{2, 16'hFFFE, 32'hC0000000};
    tbl[7] = '{3, 16'h0003, 32'h40400000};
    rr[0] = '{0, 16'h0100, 32'h43800000};
    rr[1] = '{1, 16'hFFFF, 32'hBF800000};
    rr[2] = '{2, 16'h0000, 32'h00000000};
    rr[3] = '{3, 16'h8000, 32'hC7000000};
    rr[4] = '{0, 16'h0100, 32'h43800000};

    // Reset state, with every input valid to show nothing leaks through.
    repeat (2) @(negedge clk);
    in_valid = '1; in_data = {CH{16'h1234}}; #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cvt_start", 32'(cvt_start), 32'd0);
    chk("rst_cvt_fixed", 32'(cvt_fixed), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk); reset = 1'b0; in_valid = '0; #1;

    // Table-driven single conversions.
    for (int i = 0; i < 8; i++) do_one(tbl[i].ch, tbl[i].d, tbl[i].f);

    // All four channels valid: round-robin order 0,1,2,3,0.
    @(negedge clk);
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = rr[i].d;
    in_valid = '1; out_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      wait_start("rr_start");
      chk("rr_grant", 32'(in_ready), 32'(1 << rr[i].ch));
      chk("rr_fixed", 32'(cvt_fixed), 32'(rr[i].d));
      @(negedge clk); #1;
      wait_out("rr_out");
      chk("rr_data", out_data, rr[i].f);
      chk("rr_chan", 32'(out_chan), 32'(rr[i].ch));
    end
    @(negedge clk); in_valid = '0; #1;
    wait_idle("rr_idle");

    // Back-pressure: held result blocks grants; one drain cycle grants in the same cycle.
    @(negedge clk); out_ready = 1'b0; in_data[0 +: W] = 16'h0002; in_valid[0] = 1'b1; #1;
    wait_start("bp_first");
    @(negedge clk); in_valid[0] = 1'b0; #1;
    wait_out("bp_held");
    @(negedge clk);
    in_data[1*W +: W] = 16'h0010; in_data[2*W +: W] = 16'hFFF0; in_valid[2:1] = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_start", 32'(cvt_start), 32'd0);
      chk("bp_no_ready", 32'(in_ready), 32'd0);
      chk("bp_not_busy", 32'(busy), 32'd0);
      @(negedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_grant_on_drain", 32'(cvt_start), 32'd1);
    chk("bp_grant_ch1", 32'(in_ready), 32'b0010);
    @(negedge clk); out_ready = 1'b0; in_valid[1] = 1'b0; #1;
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    wait_out("bp_out1");
    chk("bp_data1", out_data, 32'h41800000);
    chk("bp_chan1", 32'(out_chan), 32'd1);
    chk("bp_blocked", 32'(cvt_start), 32'd0);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_grant_ch2", 32'(in_ready), 32'b0100);
    @(negedge clk); in_valid[2] = 1'b0; #1;
    wait_out("bp_out2");
    chk("bp_data2", out_data, 32'hC1800000);
    chk("bp_chan2", 32'(out_chan), 32'd2);
    wait_idle("bp_idle");

    // Fairness: channel 0 hogs, channel 2 raised mid-conversion.
    @(negedge clk); in_data[0 +: W] = 16'h0007; in_valid[0] = 1'b1; #1;
    wait_start("fair_first");
    chk("fair_first_ch0", 32'(in_ready), 32'b0001);
    @(negedge clk); in_valid[2] = 1'b1; #1;
    n0 = 0; got2 = 1'b0;
    for (int n = 0; n < 300 && !got2; n++) begin
      if (cvt_start && in_ready[2]) got2 = 1'b1;
      else begin
        if (cvt_start && in_ready[0]) n0++;
        @(negedge clk); #1;
      end
    end
    chk("fair_ch2_granted", 32'(got2), 32'd1);
    chk("fair_wait_bound", 32'(n0 <= 1), 32'd1);
    @(negedge clk); in_valid = '0; #1;
    wait_idle("fair_idle");

    // Watchdog: converter never finishes.
    @(negedge clk); mode = 1; out_ready = 1'b0; in_data[3*W +: W] = 16'h0011; in_valid[3] = 1'b1; #1;
    wait_start("to_start");
    chk("to_grant_ch3", 32'(in_ready), 32'b1000);
    @(negedge clk); in_valid = '0; #1;
    bc = 0; ov = 0; tc = 0;
    for (int n = 0; n < 200 && busy; n++) begin
      bc++; if (out_valid) ov++; if (timeout) tc++;
      @(negedge clk); #1;
    end
    chk("to_busy_cycles", 32'(bc), 32'd64);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_no_early_pulse", 32'(tc), 32'd0);
    chk("to_no_out_in_busy", 32'(ov), 32'd0);
    chk("to_no_out", 32'(out_valid), 32'd0);
    @(negedge clk); mode = 0; in_data[1*W +: W] = 16'h0004; in_valid[1] = 1'b1; #1;
    chk("to_pulse_once", 32'(timeout), 32'd0);
    wait_start("to_next_start");
    chk("to_next_ch1", 32'(in_ready), 32'b0010);
    @(negedge clk); in_valid = '0; #1;
    wait_out("to_next_out");
    chk("to_next_data", out_data, 32'h40800000);
    @(negedge clk); out_ready = 1'b1; #1;
    wait_idle("to_idle");

    // Done exactly on the last watchdog cycle is a normal completion.
    @(negedge clk); mode = 2; fixed_lat = TO - 1; out_ready = 1'b0;
    in_data[2*W +: W] = 16'h0005; in_valid[2] = 1'b1; #1;
    wait_start("lim_start");
    @(negedge clk); in_valid = '0; #1;
    bc = 0; tc = 0;
    for (int n = 0; n < 200 && busy; n++) begin
      bc++; if (timeout) tc++;
      @(negedge clk); #1;
    end
    chk("lim_busy_cycles", 32'(bc), 32'd64);
    chk("lim_out_valid", 32'(out_valid), 32'd1);
    chk("lim_data", out_data, 32'h40A00000);
    chk("lim_chan", 32'(out_chan), 32'd2);
    chk("lim_no_timeout", 32'(timeout | (tc != 0)), 32'd0);
    @(negedge clk); out_ready = 1'b1; #1;
    wait_idle("lim_idle");

    // Reset mid-conversion; the converter's late done must be ignored.
    @(negedge clk); fixed_lat = 7; out_ready = 1'b0; in_valid[2] = 1'b1; #1;
    wait_start("mr_start");
    @(negedge clk); in_valid = '0; #1;
    repeat (2) @(negedge clk);
    #1; chk("mr_busy", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b1; in_valid = '1; #1;
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_cvt_start", 32'(cvt_start), 32'd0);
    chk("mr_cvt_fixed", 32'(cvt_fixed), 32'd0);
    chk("mr_busy_low", 32'(busy), 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0; in_valid = '0; #1;
    ov = 0;
    for (int n = 0; n < 12; n++) begin
      if (out_valid || busy) ov++;
      @(negedge clk); #1;
    end
    chk("mr_late_done_ignored", 32'(ov), 32'd0);
    @(negedge clk); mode = 0; in_valid = '1; #1;
    wait_start("mr_restart");
    chk("mr_rr_restart_ch0", 32'(in_ready), 32'b0001);
    @(negedge clk); in_valid = '0; #1;
    wait_out("mr_out");
    chk("mr_data", out_data, ref_float(in_data[0 +: W]));
    chk("mr_chan", 32'(out_chan), 32'd0);
    @(negedge clk); out_ready = 1'b1; #1;
    wait_idle("mr_idle");

    // Randomized traffic against a queue model.
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; #1;
    mptr = CH - 1; acc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (acc[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && $urandom_range(0, 3) == 0) begin
          in_data[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
          in_valid[i] = 1'b1;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_g = !busy && cvt_ready && (|in_valid) && (!out_valid || out_ready);
      chk("rand_grant", 32'(cvt_start), 32'(exp_g));
      e = -1;
      if (cvt_start) begin
        for (int k = CH; k >= 1; k--)
          if (in_valid[(mptr + k) % CH]) e = (mptr + k) % CH;
        chk("rand_in_ready", 32'(in_ready), (e >= 0) ? 32'(1 << e) : 32'd0);
        if (e >= 0) begin
          chk("rand_fixed", 32'(cvt_fixed), 32'(in_data[e*W +: W]));
          q.push_back('{e, ref_float(in_data[e*W +: W])});
          mptr = e;
        end
      end else begin
        chk("rand_no_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_out", 32'd1, 32'd0);
        else begin
          x = q.pop_front();
          chk("rand_data", out_data, x.f);
          chk("rand_chan", 32'(out_chan), 32'(x.ch));
        end
      end
      acc = in_ready;
    end
    @(negedge clk); in_valid = '0; out_ready = 1'b1; #1;
    for (int n = 0; n < 300 && (q.size() != 0 || busy || out_valid); n++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("drain_unexpected_out", 32'd1, 32'd0);
        else begin
          x = q.pop_front();
          chk("drain_data", out_data, x.f);
          chk("drain_chan", 32'(out_chan), 32'(x.ch));
        end
      end
      @(negedge clk); #1;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
